nor_tree_pipe: RTL and testbench

Parametrised, pipelined N-input NOR reduction cell for the power-characterisation flow. It generalises the fixed 3-input NOR primitive to any input count. The reduction is built as a tree of FANIN-wide OR levels, with one register per level and a final inversion. It adds a valid-qualified pipeline and an optional saturating output-toggle counter, so power benches can correlate switching activity with measured energy.

---
 rtl/nor_tree_pipe.sv | 129 ++++++++++++
 tb/tb_nor_tree_pipe.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/nor_tree_pipe.sv
// nor_tree_pipe: pipelined WIDTH-input NOR built as a tree of FANIN-wide OR levels.
// Optional toggle counter (last_qn, TOG_CNT, SAT) is built when NOR_TREE_TOGCNT_EN is defined.
module nor_tree_pipe #(
    parameter int WIDTH = 3,
    parameter int FANIN = 3,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] IN,
    input  logic             IN_VLD,
    input  logic             TOG_CLR,
    output logic             QN,
    output logic             QN_VLD,
    output logic [CNT_W-1:0] TOG_CNT,
    output logic             SAT
);
    function automatic int calc_levels(input int w, input int f);
        int l;
        int span;
        l    = 1;
        span = f;
        while (span < w) begin
            span = span * f;
            l    = l + 1;
        end
        return l;
    endfunction

    localparam int LEVELS = calc_levels(WIDTH, FANIN);
    localparam int PAD    = FANIN ** LEVELS;

    logic [PAD-1:0]    pad_in;
    logic [LEVELS-1:0] vld_q;

    // Zero padding is the OR identity, so unused leaves never affect the result.
    assign pad_in = PAD'(IN);

    always_ff @(posedge CLK) begin
        if (RST) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= IN_VLD;
            for (int i = 1; i < LEVELS; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
    end

    for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
        localparam int NODES = FANIN ** (LEVELS - l);
        localparam bit LAST  = (l == LEVELS);

        logic [NODES*FANIN-1:0] src;
        logic [NODES-1:0]       or_d;
        logic [NODES-1:0]       node_q;
        logic                   load;

        if (l == 1) begin : g_first
            assign src  = pad_in;
            assign load = IN_VLD;
        end else begin : g_next
            assign src  = g_lvl[l-1].node_q;
            assign load = vld_q[l-2];
        end

        always_comb begin
            or_d = '0;
            for (int n = 0; n < NODES; n++) begin
                or_d[n] = |src[n*FANIN +: FANIN];
            end
        end

        // Levels hold during bubbles; the last level stores the inverted OR (QN).
        always_ff @(posedge CLK) begin
            if (RST) begin
                node_q <= {NODES{LAST}};
            end else if (load) begin
                node_q <= LAST ? ~or_d : or_d;
            end
        end
    end

    assign QN     = g_lvl[LEVELS].node_q[0];
    assign QN_VLD = vld_q[LEVELS-1];

`ifdef NOR_TREE_TOGCNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             last_qn;
    logic [CNT_W-1:0] tog_cnt_q;
    logic             sat_q;
    logic             toggle;

    assign toggle = QN_VLD && (QN != last_qn);

    // Clear beats a simultaneous toggle for the count, but last_qn still tracks QN.
    always_ff @(posedge CLK) begin
        if (RST) begin
            last_qn   <= 1'b1;
            tog_cnt_q <= '0;
            sat_q     <= 1'b0;
        end else begin
            if (toggle) begin
                last_qn <= QN;
            end
            if (TOG_CLR) begin
                tog_cnt_q <= '0;
                sat_q     <= 1'b0;
            end else if (toggle && (tog_cnt_q != CNT_MAX)) begin
                tog_cnt_q <= tog_cnt_q + 1'b1;
                if (tog_cnt_q == CNT_MAX - 1'b1) begin
                    sat_q <= 1'b1;
                end
            end
        end
    end

    assign TOG_CNT = tog_cnt_q;
    assign SAT     = sat_q;
`else
    logic unused_tog_clr;

    assign unused_tog_clr = TOG_CLR;
    assign TOG_CNT        = '0;
    assign SAT            = 1'b0;
`endif

endmodule

// File: tb/tb_nor_tree_pipe.sv
// Scoreboard bench for nor_tree_pipe: three instances (3/3, 9/3, 64/4) driven with directed vectors.
// Toggle-counter expectations follow whether NOR_TREE_TOGCNT_EN is defined for the build.
module tb_nor_tree_pipe;
`ifdef NOR_TREE_TOGCNT_EN
    localparam bit TOG_EN = 1'b1;
`else
    localparam bit TOG_EN = 1'b0;
`endif

    typedef struct {
        logic qn;
        int   due;
    } exp_t;

    logic clk = 1'b0;
    int   edge_n = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    exp_t q3[$];
    exp_t q9[$];
    exp_t q64[$];
    exp_t e3, e9, e64;

    logic        rst3 = 1'b1, vld3 = 1'b0, clr3 = 1'b0, qn3, qv3, sat3;
    logic [2:0]  in3 = '0;
    logic [3:0]  cnt3;
    logic        rst9 = 1'b1, vld9 = 1'b0, qn9, qv9, sat9;
    logic [8:0]  in9 = '0;
    logic [15:0] cnt9;
    logic        rst64 = 1'b1, vld64 = 1'b0, qn64, qv64, sat64;
    logic [63:0] in64 = '0;
    logic [15:0] cnt64;

    always #5 clk = ~clk;
    always @(posedge clk) edge_n <= edge_n + 1;

    nor_tree_pipe #(.WIDTH(3), .FANIN(3), .CNT_W(4)) u_d3 (
        .CLK(clk), .RST(rst3), .IN(in3), .IN_VLD(vld3), .TOG_CLR(clr3),
        .QN(qn3), .QN_VLD(qv3), .TOG_CNT(cnt3), .SAT(sat3));

    nor_tree_pipe #(.WIDTH(9), .FANIN(3), .CNT_W(16)) u_d9 (
        .CLK(clk), .RST(rst9), .IN(in9), .IN_VLD(vld9), .TOG_CLR(1'b0),
        .QN(qn9), .QN_VLD(qv9), .TOG_CNT(cnt9), .SAT(sat9));

    nor_tree_pipe #(.WIDTH(64), .FANIN(4), .CNT_W(16)) u_d64 (
        .CLK(clk), .RST(rst64), .IN(in64), .IN_VLD(vld64), .TOG_CLR(1'b0),
        .QN(qn64), .QN_VLD(qv64), .TOG_CNT(cnt64), .SAT(sat64));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    // Monitors: pop one expectation per valid output, checking value and arrival edge.
    always @(negedge clk) begin
        if (qv3 === 1'b1) begin
            if (q3.size() == 0) chk("d3 unexpected valid", 64'd1, 64'd0);
            else begin
                e3 = q3.pop_front();
                chk("d3 qn", 64'(qn3), 64'(e3.qn));
                chk("d3 latency", 64'(edge_n), 64'(e3.due));
            end
        end
    end

    always @(negedge clk) begin
        if (qv9 === 1'b1) begin
            if (q9.size() == 0) chk("d9 unexpected valid", 64'd1, 64'd0);
            else begin
                e9 = q9.pop_front();
                chk("d9 qn", 64'(qn9), 64'(e9.qn));
                chk("d9 latency", 64'(edge_n), 64'(e9.due));
            end
        end
    end

    always @(negedge clk) begin
        if (qv64 === 1'b1) begin
            if (q64.size() == 0) chk("d64 unexpected valid", 64'd1, 64'd0);
            else begin
                e64 = q64.pop_front();
                chk("d64 qn", 64'(qn64), 64'(e64.qn));
                chk("d64 latency", 64'(edge_n), 64'(e64.due));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A vector driven just after edge E is accepted at E+1 and appears after edge E+LEVELS.
    task automatic send3(input logic [2:0] v, input logic valid);
        in3  = v;
        vld3 = valid;
        if (valid) q3.push_back('{qn: ~|v, due: edge_n + 1});
        tick();
    endtask

    task automatic send9(input logic [8:0] v, input logic valid);
        in9  = v;
        vld9 = valid;
        if (valid) q9.push_back('{qn: ~|v, due: edge_n + 2});
        tick();
    endtask

    task automatic send64(input logic [63:0] v, input logic valid);
        in64  = v;
        vld64 = valid;
        if (valid) q64.push_back('{qn: ~|v, due: edge_n + 3});
        tick();
    endtask

    task automatic idle(input int n);
        vld3  = 1'b0;
        vld9  = 1'b0;
        vld64 = 1'b0;
        clr3  = 1'b0;
        repeat (n) tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, edge %0d", edge_n);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values on all three instances.
        tick();
        tick();
        rst3  = 1'b0;
        rst9  = 1'b0;
        rst64 = 1'b0;
        chk("d3 reset qn", 64'(qn3), 64'd1);
        chk("d3 reset qn_vld", 64'(qv3), 64'd0);
        chk("d3 reset tog_cnt", 64'(cnt3), 64'd0);
        chk("d3 reset sat", 64'(sat3), 64'd0);
        chk("d9 reset qn", 64'(qn9), 64'd1);
        chk("d9 reset qn_vld", 64'(qv9), 64'd0);
        chk("d64 reset qn", 64'(qn64), 64'd1);
        chk("d64 reset qn_vld", 64'(qv64), 64'd0);
        chk("d64 reset tog_cnt", 64'(cnt64), 64'd0);

        send3(3'b000, 1'b1);
        idle(2);

        // Saturation: 20 alternating toggles on the 4-bit counter.
        for (int i = 0; i < 20; i++) send3((i % 2 == 0) ? 3'b001 : 3'b000, 1'b1);
        idle(2);
        chk("d3 sat tog_cnt", 64'(cnt3), TOG_EN ? 64'd15 : 64'd0);
        chk("d3 sat flag", 64'(sat3), TOG_EN ? 64'd1 : 64'd0);

        // Clear coincident with a toggle: clear wins, last_qn still follows QN.
        send3(3'b001, 1'b1);
        vld3 = 1'b0;
        clr3 = 1'b1;
        tick();
        clr3 = 1'b0;
        chk("d3 clr tog_cnt", 64'(cnt3), 64'd0);
        chk("d3 clr sat", 64'(sat3), 64'd0);
        send3(3'b000, 1'b1);
        idle(2);
        chk("d3 post-clr tog_cnt", 64'(cnt3), TOG_EN ? 64'd1 : 64'd0);

        // Two-level latency on the 9-input tree.
        send9(9'h100, 1'b1);
        idle(4);

        // Streaming with a bubble after a fresh reset; the bubble carries junk data.
        rst9 = 1'b1;
        tick();
        rst9 = 1'b0;
        send9(9'h000, 1'b1);
        send9(9'h1ff, 1'b0);
        send9(9'h001, 1'b1);
        send9(9'h000, 1'b1);
        idle(3);
        chk("d9 stream tog_cnt", 64'(cnt9), TOG_EN ? 64'd2 : 64'd0);
        chk("d9 stream sat", 64'(sat9), 64'd0);
        chk("d9 stream held qn", 64'(qn9), 64'd1);

        // 64-input tree: top bit must reach the output through padding-free levels.
        send64(64'h8000_0000_0000_0000, 1'b1);
        idle(5);
        chk("d64 pre tog_cnt", 64'(cnt64), TOG_EN ? 64'd1 : 64'd0);

        // Reset mid-pipeline: only the first of three vectors escapes before reset.
        send64(64'h0000_0000_0000_0010, 1'b1);
        send64(64'h0, 1'b1);
        send64(64'h0, 1'b1);
        vld64 = 1'b0;
        rst64 = 1'b1;
        while (q64.size() > 0 && q64[$].due > edge_n) void'(q64.pop_back());
        tick();
        rst64 = 1'b0;
        chk("d64 rst tog_cnt", 64'(cnt64), 64'd0);
        send64(64'h0, 1'b1);
        idle(4);
        chk("d64 post-rst tog_cnt", 64'(cnt64), 64'd0);
        chk("d64 post-rst sat", 64'(sat64), 64'd0);

        idle(3);
        chk("d3 queue drained", 64'(q3.size()), 64'd0);
        chk("d9 queue drained", 64'(q9.size()), 64'd0);
        chk("d64 queue drained", 64'(q64.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
